// File: rtl/gd_pkg.sv
// Shared Q24.8 constants, result payload and sweep FSM state type for the
// gradient-descent multi-start controller.
package gd_pkg;

  localparam int unsigned FRAC_BITS = 8;
  localparam int unsigned DATA_W    = 32;
  localparam int unsigned Y_W       = 64;
  localparam int unsigned IDX_W     = 8;

  localparam logic [DATA_W-1:0] ONE = 32'h0000_0100;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_DONE,
    RELEASE,
    WAIT_CLEAR,
    FINISH
  } state_t;

  // One Top result: location of the minimum and its value
  typedef struct packed {
    logic [Y_W-1:0]    y;
    logic [DATA_W-1:0] x;
  } result_t;

endpackage

// File: rtl/multistart_sweep_ctrl_if.sv
// start_op/x_init launch handshake and result return path between the
// multi-start controller (master) and the gradient-descent Top (slave).
interface multistart_sweep_ctrl_if;

  logic                        start_op;
  logic [gd_pkg::DATA_W-1:0]   x_init;
  logic                        done_op;
  logic [gd_pkg::DATA_W-1:0]   x_at_min;
  logic [gd_pkg::Y_W-1:0]      y_min;

  modport master (
    output start_op,
    output x_init,
    input  done_op,
    input  x_at_min,
    input  y_min
  );

  modport slave (
    input  start_op,
    input  x_init,
    output done_op,
    output x_at_min,
    output y_min
  );

endinterface

// File: rtl/best_tracker.sv
// Keeps the lowest y_min seen in the current sweep along with its x and run
// index; a strict signed compare lets earlier runs win ties.
module best_tracker
  import gd_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clr,
  input  logic              upd,
  input  logic [IDX_W-1:0]  idx,
  input  result_t           res,
  output logic [DATA_W-1:0] best_x,
  output logic [Y_W-1:0]    best_y,
  output logic [IDX_W-1:0]  best_idx
);

  logic best_valid;
  logic better_c;

  assign better_c = !best_valid || ($signed(res.y) < $signed(best_y));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      best_x     <= '0;
      best_y     <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
    end else if (clr) begin
      best_x     <= '0;
      best_y     <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
    end else if (upd && better_c) begin
      best_x     <= res.x;
      best_y     <= res.y;
      best_idx   <= idx;
      best_valid <= 1'b1;
    end
  end

endmodule

// File: rtl/multistart_sweep_ctrl.sv
// Multi-start sweep controller: launches Top once per initial point
// x_first + k*x_step, tracks the lowest minimum and aborts on a stalled wait.
module multistart_sweep_ctrl
  import gd_pkg::*;
#(
  parameter int unsigned NUM_STARTS     = 10,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned CNT_W          = 13
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   sweep_start,
  input  logic [DATA_W-1:0]      x_first,
  input  logic [DATA_W-1:0]      x_step,
  multistart_sweep_ctrl_if.master gd,
  output logic                   busy,
  output logic                   sweep_done,
  output logic [DATA_W-1:0]      best_x,
  output logic [Y_W-1:0]         best_y,
  output logic [IDX_W-1:0]       best_idx,
  output logic                   timeout_err
);

  localparam logic [IDX_W-1:0] LAST_K     = IDX_W'(NUM_STARTS - 1);
  localparam logic [CNT_W-1:0] WD_LIMIT   = CNT_W'(TIMEOUT_CYCLES);

  state_t            state, state_d;
  logic [IDX_W-1:0]  k, k_d;
  logic [DATA_W-1:0] x_init_q, x_init_d;
  logic [DATA_W-1:0] step_q, step_d;
  logic              start_q, start_d;
  logic [CNT_W-1:0]  wdog, wdog_d;
  logic [CNT_W-1:0]  wd_inc_c;
  logic              busy_d, sweep_done_d, timeout_err_d;
  logic              clr_c, upd_c;
  result_t           res_c;

  assign gd.start_op = start_q;
  assign gd.x_init   = x_init_q;
  assign wd_inc_c    = wdog + CNT_W'(1);
  assign res_c.x     = gd.x_at_min;
  assign res_c.y     = gd.y_min;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      k           <= '0;
      x_init_q    <= '0;
      step_q      <= '0;
      start_q     <= 1'b0;
      wdog        <= '0;
      busy        <= 1'b0;
      sweep_done  <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_d;
      k           <= k_d;
      x_init_q    <= x_init_d;
      step_q      <= step_d;
      start_q     <= start_d;
      wdog        <= wdog_d;
      busy        <= busy_d;
      sweep_done  <= sweep_done_d;
      timeout_err <= timeout_err_d;
    end
  end

  // Next-state and next-output logic
  always_comb begin
    state_d       = state;
    k_d           = k;
    x_init_d      = x_init_q;
    step_d        = step_q;
    start_d       = start_q;
    wdog_d        = wdog;
    busy_d        = busy;
    sweep_done_d  = sweep_done;
    timeout_err_d = timeout_err;
    clr_c         = 1'b0;
    upd_c         = 1'b0;

    unique case (state)
      IDLE: begin
        if (sweep_start) begin
          x_init_d      = x_first;
          step_d        = x_step;
          k_d           = '0;
          timeout_err_d = 1'b0;
          busy_d        = 1'b1;
          clr_c         = 1'b1;
          state_d       = LAUNCH;
        end
      end

      LAUNCH: begin
        start_d = 1'b1;
        wdog_d  = '0;
        state_d = WAIT_DONE;
      end

      WAIT_DONE: begin
        if (gd.done_op) begin
          upd_c   = 1'b1;
          start_d = 1'b0;
          state_d = RELEASE;
        end else if (wd_inc_c == WD_LIMIT) begin
          start_d       = 1'b0;
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          sweep_done_d  = 1'b1;
          state_d       = FINISH;
        end else begin
          wdog_d = wd_inc_c;
        end
      end

      RELEASE: begin
        wdog_d  = '0;
        state_d = WAIT_CLEAR;
      end

      WAIT_CLEAR: begin
        if (!gd.done_op) begin
          if (k == LAST_K) begin
            busy_d       = 1'b0;
            sweep_done_d = 1'b1;
            state_d      = FINISH;
          end else begin
            // x_init wraps in 32-bit two's complement
            k_d      = k + IDX_W'(1);
            x_init_d = x_init_q + step_q;
            state_d  = LAUNCH;
          end
        end else if (wd_inc_c == WD_LIMIT) begin
          start_d       = 1'b0;
          timeout_err_d = 1'b1;
          busy_d        = 1'b0;
          sweep_done_d  = 1'b1;
          state_d       = FINISH;
        end else begin
          wdog_d = wd_inc_c;
        end
      end

      FINISH: begin
        if (!sweep_start) begin
          sweep_done_d = 1'b0;
          state_d      = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  best_tracker u_best (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (clr_c),
    .upd      (upd_c),
    .idx      (k),
    .res      (res_c),
    .best_x   (best_x),
    .best_y   (best_y),
    .best_idx (best_idx)
  );

endmodule

// File: tb/tb_multistart_sweep_ctrl.sv
// Directed bench for multistart_sweep_ctrl with a behavioural mock of Top
// returning x_at_min = x_init and y_min from a per-run table.
module tb_multistart_sweep_ctrl;

  logic        clk;
  logic        rst_n;
  logic        sweep_start;
  logic [31:0] x_first;
  logic [31:0] x_step;
  logic        busy;
  logic        sweep_done;
  logic [31:0] best_x;
  logic [63:0] best_y;
  logic [7:0]  best_idx;
  logic        timeout_err;

  multistart_sweep_ctrl_if gd_if ();

  multistart_sweep_ctrl #(
    .NUM_STARTS     (4),
    .TIMEOUT_CYCLES (64),
    .CNT_W          (13)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sweep_start (sweep_start),
    .x_first     (x_first),
    .x_step      (x_step),
    .gd          (gd_if),
    .busy        (busy),
    .sweep_done  (sweep_done),
    .best_x      (best_x),
    .best_y      (best_y),
    .best_idx    (best_idx),
    .timeout_err (timeout_err)
  );

  int          n_cmp    = 0;
  int          n_bad    = 0;
  int          rises    = 0;
  int          base     = 0;
  int          hang_run = -1;
  int          viol     = 0;
  logic [63:0] tbl [4];
  logic [31:0] xs  [8];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Mock Top: done_op 5 cycles after start_op rises, drops 2 cycles after it falls
  initial begin
    automatic bit          prev    = 1'b0;
    automatic int          hi      = 0;
    automatic int          lo      = 0;
    automatic int          cur_idx = 0;
    automatic logic [31:0] cur_x   = '0;
    gd_if.done_op  = 1'b0;
    gd_if.x_at_min = '0;
    gd_if.y_min    = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        gd_if.done_op = 1'b0;
        prev = 1'b0;
        hi   = 0;
        lo   = 0;
      end else begin
        if (gd_if.start_op && !prev) begin
          cur_idx = rises - base;
          rises   = rises + 1;
          cur_x   = gd_if.x_init;
          if (cur_idx >= 0 && cur_idx < 8) xs[3'(cur_idx)] = cur_x;
          hi = 0;
          lo = 0;
        end
        if (gd_if.start_op) begin
          if (gd_if.x_init !== cur_x) viol = viol + 1;
          if (!gd_if.done_op && cur_idx != hang_run) begin
            hi = hi + 1;
            if (hi == 5) begin
              gd_if.done_op  = 1'b1;
              gd_if.x_at_min = cur_x;
              gd_if.y_min    = tbl[2'(cur_idx)];
            end
          end
        end else if (gd_if.done_op) begin
          lo = lo + 1;
          if (lo == 2) begin
            gd_if.done_op = 1'b0;
            lo = 0;
          end
        end
        prev = gd_if.start_op;
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp = n_cmp + 1;
    assert (obs === exp) else begin
      n_bad = n_bad + 1;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic set_tbl(input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [63:0] d);
    tbl[0] = a;
    tbl[1] = b;
    tbl[2] = c;
    tbl[3] = d;
  endtask

  task automatic wait_sweep_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < limit; i++) begin
      @(negedge clk);
      if (sweep_done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Start a sweep and hold sweep_start high until FINISH is reached
  task automatic run_sweep(input logic [31:0] xf, input logic [31:0] xst, output bit ok);
    base        = rises;
    x_first     = xf;
    x_step      = xst;
    sweep_start = 1'b1;
    wait_sweep_done(400, ok);
  endtask

  task automatic end_sweep();
    sweep_start = 1'b0;
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    automatic bit ok;
    rst_n       = 1'b0;
    sweep_start = 1'b0;
    x_first     = '0;
    x_step      = '0;
    set_tbl(64'd0, 64'd0, 64'd0, 64'd0);
    repeat (3) @(negedge clk);
    chk("rst_busy",       64'(busy),           64'd0);
    chk("rst_sweep_done", 64'(sweep_done),     64'd0);
    chk("rst_start_op",   64'(gd_if.start_op), 64'd0);
    chk("rst_timeout",    64'(timeout_err),    64'd0);
    chk("rst_best_y",     best_y,              64'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic sweep, with mid-sweep x_first/x_step changes that must be ignored
    set_tbl(64'd40, 64'd12, 64'd25, 64'd30);
    base        = rises;
    x_first     = 32'h0000_0000;
    x_step      = 32'hFFFF_FF00;
    sweep_start = 1'b1;
    @(negedge clk);
    chk("accept_busy", 64'(busy), 64'd1);
    x_first = 32'h1234_5678;
    x_step  = 32'h0000_0001;
    wait_sweep_done(400, ok);
    chk("basic_done_seen", 64'(ok),     64'd1);
    chk("basic_x0",        64'(xs[0]),  64'h0000_0000);
    chk("basic_x1",        64'(xs[1]),  64'hFFFF_FF00);
    chk("basic_x2",        64'(xs[2]),  64'hFFFF_FE00);
    chk("basic_x3",        64'(xs[3]),  64'hFFFF_FD00);
    chk("basic_best_idx",  64'(best_idx), 64'd1);
    chk("basic_best_y",    best_y,        64'd12);
    chk("basic_best_x",    64'(best_x),   64'hFFFF_FF00);
    chk("basic_timeout",   64'(timeout_err), 64'd0);
    chk("basic_busy_low",  64'(busy),        64'd0);
    repeat (3) @(negedge clk);
    chk("finish_hold", 64'(sweep_done), 64'd1);
    sweep_start = 1'b0;
    @(negedge clk);
    chk("finish_release", 64'(sweep_done), 64'd0);
    chk("best_persist",   64'(best_idx),   64'd1);
    chk("x_init_stable",  64'(viol),       64'd0);
    @(negedge clk);

    // Ties keep the earlier index
    set_tbl(64'd7, 64'd7, 64'd3, 64'd3);
    run_sweep(32'h0000_0000, 32'hFFFF_FF00, ok);
    chk("tie_done_seen", 64'(ok),       64'd1);
    chk("tie_best_idx",  64'(best_idx), 64'd2);
    chk("tie_best_y",    best_y,        64'd3);
    chk("tie_best_x",    64'(best_x),   64'hFFFF_FE00);
    end_sweep();

    // Signed comparison
    set_tbl(64'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFF0, 64'd0);
    run_sweep(32'h0000_0000, 32'hFFFF_FF00, ok);
    chk("neg_done_seen", 64'(ok),       64'd1);
    chk("neg_best_idx",  64'(best_idx), 64'd2);
    chk("neg_best_y",    best_y,        64'hFFFF_FFFF_FFFF_FFF0);
    end_sweep();

    // Re-raised sweep starts from a fresh best
    set_tbl(64'd50, 64'd60, 64'd70, 64'd80);
    run_sweep(32'h0000_0000, 32'hFFFF_FF00, ok);
    chk("reinit_done_seen", 64'(ok),       64'd1);
    chk("reinit_best_idx",  64'(best_idx), 64'd0);
    chk("reinit_best_y",    best_y,        64'd50);
    chk("reinit_best_x",    64'(best_x),   64'd0);
    end_sweep();

    // Watchdog abort on run 2
    set_tbl(64'd9, 64'd4, 64'd1, 64'd0);
    hang_run = 2;
    run_sweep(32'h0000_0100, 32'h0000_0100, ok);
    chk("to_done_seen",  64'(ok),             64'd1);
    chk("to_err",        64'(timeout_err),    64'd1);
    chk("to_start_op",   64'(gd_if.start_op), 64'd0);
    chk("to_busy",       64'(busy),           64'd0);
    chk("to_runs",       64'(rises - base),   64'd3);
    chk("to_best_idx",   64'(best_idx),       64'd1);
    chk("to_best_y",     best_y,              64'd4);
    chk("to_best_x",     64'(best_x),         64'h0000_0200);
    hang_run = -1;
    end_sweep();
    chk("to_err_persist", 64'(timeout_err), 64'd1);

    // x_init wrap, then asynchronous reset during run 3
    set_tbl(64'd1, 64'd2, 64'd3, 64'd4);
    base        = rises;
    x_first     = 32'h7FFF_FF00;
    x_step      = 32'h0000_0100;
    sweep_start = 1'b1;
    ok          = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (rises - base == 4) begin
        ok = 1'b1;
        break;
      end
    end
    chk("wrap_run3_seen", 64'(ok),    64'd1);
    chk("wrap_x1",        64'(xs[1]), 64'h8000_0000);
    chk("wrap_x2",        64'(xs[2]), 64'h8000_0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_start_op",  64'(gd_if.start_op), 64'd0);
    chk("arst_x_init",    64'(gd_if.x_init),   64'd0);
    chk("arst_busy",      64'(busy),           64'd0);
    chk("arst_best_x",    64'(best_x),         64'd0);
    chk("arst_best_y",    best_y,              64'd0);
    sweep_start = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("post_rst_busy",  64'(busy),           64'd0);
    chk("post_rst_start", 64'(gd_if.start_op), 64'd0);
    chk("post_rst_done",  64'(sweep_done),     64'd0);

    // Controller accepts a fresh sweep from IDLE after reset
    set_tbl(64'd40, 64'd12, 64'd25, 64'd30);
    run_sweep(32'h0000_0000, 32'hFFFF_FF00, ok);
    chk("again_done_seen", 64'(ok),       64'd1);
    chk("again_best_idx",  64'(best_idx), 64'd1);
    chk("again_best_x",    64'(best_x),   64'hFFFF_FF00);
    end_sweep();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/multistart_sweep_ctrl.md
Name: multistart_sweep_ctrl

Overview:
- Multi-start controller placed directly upstream of the fixed-point gradient-descent Top.
- Drives Top's start_op/x_init handshake for NUM_STARTS initial points x_first + k*x_step.
- Consumes each x_at_min/y_min result and keeps the best (lowest) minimum.
- Replaces the hand-written sweep loop with synthesizable hardware.

Parameters:
- NUM_STARTS, 10: number of Top runs per sweep (1..255).
- TIMEOUT_CYCLES, 4096: maximum cycles allowed in any wait state before abort.
- CNT_W, 13: width of the watchdog counter; must hold TIMEOUT_CYCLES.

Ports:
- clk  in  1  system clock; all logic is rising-edge.
- rst_n  in  1  asynchronous, active-low reset.
- sweep_start  in  1  level request; sampled only in IDLE.
- x_first  in  32  signed Q24.8 first initial point; latched at sweep start.
- x_step  in  32  signed Q24.8 step added per run; latched at sweep start.
- start_op  out  1  to Top.start_op.
- x_init  out  32  to Top.x_init; stable whenever start_op=1.
- done_op  in  1  from Top.done_op.
- x_at_min  in  32  signed Q24.8 from Top.
- y_min  in  64  signed from Top.
- busy  out  1  high from sweep accept until FINISH.
- sweep_done  out  1  high in FINISH.
- best_x  out  32  x_at_min of the best run.
- best_y  out  64  y_min of the best run.
- best_idx  out  8  run index k (0-based) of the best run.
- timeout_err  out  1  sweep aborted by the watchdog.

Behaviour:
- Reset: all outputs 0; FSM=IDLE; watchdog, run counter and best_valid cleared.
- All outputs are registered.
- FSM states: IDLE, LAUNCH, WAIT_DONE, RELEASE, WAIT_CLEAR, FINISH.
- IDLE:
  - If sweep_start=1, latch x_first and x_step.
  - Set x_init=x_first, k=0, best_valid=0, timeout_err=0, busy=1.
  - Go to LAUNCH.
- LAUNCH:
  - start_op<=1, watchdog cleared, then WAIT_DONE.
  - x_init is valid no later than the cycle start_op rises.
- WAIT_DONE:
  - On done_op=1, capture x_at_min and y_min that same cycle.
  - Update best if !best_valid or y_min < best_y (signed, strict). Ties keep the earlier index.
  - On update, set best_idx=k and best_valid=1.
  - start_op<=0, go to RELEASE.
- RELEASE: one cycle, then WAIT_CLEAR with the watchdog cleared.
- WAIT_CLEAR:
  - On done_op=0: if k==NUM_STARTS-1, go to FINISH.
  - Otherwise k<=k+1, x_init<=x_init+x_step, go to LAUNCH.
- x_init arithmetic is 32-bit two's complement. It wraps on overflow, with no saturation.
- Watchdog:
  - Increments every cycle in WAIT_DONE and WAIT_CLEAR.
  - On reaching TIMEOUT_CYCLES: start_op<=0, timeout_err<=1, go to FINISH.
  - best_* values keep whatever has been captured so far.
- FINISH:
  - busy=0, sweep_done=1.
  - Hold until sweep_start=0, then clear sweep_done and return to IDLE.
  - best_* and timeout_err persist until the next accepted sweep.
- sweep_start changes outside IDLE/FINISH are ignored. x_first/x_step changes mid-sweep have no effect.
- done_op=1 already present at LAUNCH: captured on the first WAIT_DONE cycle. There is no stale-result protection; Top guarantees done_op=0 before start.
- Asynchronous reset mid-sweep drops start_op immediately and discards all results.
- Minimum latency per run: LAUNCH 1 + Top latency + RELEASE 1 + clear latency.

Decomposition:
- Shared package gd_pkg holds:
  - Q-format constants FRAC_BITS=8 and DATA_W=32, Y_W=64.
  - The FSM state typedef.
  - Q24.8 helper constants (ONE=32'h100).
- One natural sub-module: best_tracker, which holds the compare/update register set for best_x, best_y, best_idx and best_valid.
- The FSM stays in the top of this block.

Test Plan:
- Mock Top in the bench: done_op 5 cycles after start_op rises, and drops 2 cycles after start_op falls. x_at_min=x_init; y_min = table[k].
- Basic sweep: x_first=0, x_step=-32'h100, NUM_STARTS=4, table={40,12,25,30} -> x_init sequence 0,-256,-512,-768; best_idx=1, best_y=12, best_x=32'hFFFFFF00; sweep_done=1, timeout_err=0.
- Tie handling: table={7,7,3,3} -> best_idx=2, best_y=3.
- Negative y: table={5,-1,-64'sh10,0} -> best_idx=2 (signed compare); run again with sweep_start re-raised -> best values re-initialized.
- Timeout: mock never asserts done_op on run 2 -> timeout_err=1 at TIMEOUT_CYCLES, start_op=0, best_idx from runs 0..1, sweep_done=1.
- Wrap and reset: x_first=32'h7FFFFF00, x_step=32'h100 -> second x_init=32'h80000000. Assert rst_n=0 during run 3 -> start_op=0 and all outputs 0 asynchronously; after release the FSM is in IDLE.
